// File: rtl/pulse_stretch.sv
// pulse_stretch: replays each rising edge of sig_i as a fixed-width high pulse followed by a fixed low gap.
// Build macro PULSE_STRETCH_QUEUE_EN queues events that arrive while a pulse or gap is running.
module pulse_stretch #(
  parameter int CLK_PERIOD_ns  = 20,
  parameter int PULSE_TIMER_ns = 50_000_000,
  parameter int GAP_TIMER_ns   = 50_000_000,
  parameter int MAX_PENDING    = 7,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          sig_i,
  output logic          sig_o,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int ON_RAW     = PULSE_TIMER_ns / CLK_PERIOD_ns;
  localparam int GAP_RAW    = GAP_TIMER_ns / CLK_PERIOD_ns;
  localparam int ON_CYCLES  = (ON_RAW < 32'sd1) ? 32'sd1 : ON_RAW;
  localparam int GAP_CYCLES = (GAP_RAW < 32'sd1) ? 32'sd1 : GAP_RAW;
  localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 32'sd1);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 32'sd1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 32'sd1);
`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [PW-1:0] pend_r, pend_s;
  logic          ovf_r, ovf_s;
  logic          absorb_s;
  logic          sig_d_r, evt_r;
  logic          sig_o_r, busy_r;

  // Next state, phase counter, queue depth and overflow from the registered event
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pend_s   = pend_r;
    ovf_s    = ovf_r;
    absorb_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = '0;
        if (evt_r) begin
          state_s = ST_HIGH;
        end
`ifdef PULSE_STRETCH_QUEUE_EN
        else if (pend_r != '0) begin
          state_s = ST_HIGH;
          pend_s  = pend_r - PW'(1'b1);
        end
`endif
        else begin
          state_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        absorb_s = evt_r;
        if (cnt_r == ON_LAST) begin
          state_s = ST_GAP;
          cnt_s   = '0;
        end else begin
          state_s = ST_HIGH;
          cnt_s   = cnt_r + CW'(1'b1);
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s = '0;
`ifdef PULSE_STRETCH_QUEUE_EN
          // A fresh event on the last gap cycle starts directly, so replay spacing stays exact
          if (evt_r || (pend_r != '0)) begin
            state_s = ST_HIGH;
            if (evt_r) begin
              pend_s = pend_r;
            end else begin
              pend_s = pend_r - PW'(1'b1);
            end
          end else begin
            state_s = ST_IDLE;
          end
`else
          state_s  = ST_IDLE;
          absorb_s = evt_r;
`endif
        end else begin
          state_s  = ST_GAP;
          cnt_s    = cnt_r + CW'(1'b1);
          absorb_s = evt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase

    if (absorb_s) begin
`ifdef PULSE_STRETCH_QUEUE_EN
      if (pend_r == PEND_MAX) begin
        ovf_s = 1'b1;
      end else begin
        pend_s = pend_r + PW'(1'b1);
      end
`else
      ovf_s = 1'b1;
`endif
    end else begin
      ovf_s = ovf_r;
    end
  end

  // State, edge-detect and output registers; enable low freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_d_r <= sig_i;
      evt_r   <= 1'b0;
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      pend_r  <= '0;
      ovf_r   <= 1'b0;
      sig_o_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (enable) begin
      sig_d_r <= sig_i;
      evt_r   <= sig_i & ~sig_d_r;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      sig_o_r <= (state_s == ST_HIGH);
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign sig_o    = sig_o_r;
  assign busy     = busy_r;
  assign pending  = pend_r;
  assign overflow = ovf_r;

endmodule
